// File: rtl/ceespu_int_ctrl.sv
// ceespu_int_ctrl: edge-latched, maskable, fixed-priority interrupt controller for the
// ceespu core, configured through a 4-word memory-mapped register window.
// Optional macro CEESPU_INTC_SYNC_EN adds a 2-flop synchronizer on every I_irq line.
module ceespu_int_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [NUM_IRQ-1:0] I_irq,
    output logic               O_int_req,
    output logic [2:0]         O_int_vector,
    input  logic               I_int_ack,
    input  logic               I_busE,
    input  logic               I_busWe,
    input  logic [3:0]         I_busAddr,
    input  logic [31:0]        I_busWData,
    output logic [31:0]        O_busRData
);

    localparam int unsigned VEC_W  = 3;
    localparam int unsigned DATA_W = 32;

`ifdef CEESPU_INTC_SYNC_EN
    // Reset-low sync flops create a false rising edge for lines held high, so
    // edge detection stays disarmed until the pipeline has filled.
    localparam logic [1:0] ARM_CYCLES = 2'd3;
`else
    localparam logic [1:0] ARM_CYCLES = 2'd1;
`endif

    localparam logic [1:0] SEL_PENDING = 2'd0;
    localparam logic [1:0] SEL_MASK    = 2'd1;
    localparam logic [1:0] SEL_ACTIVE  = 2'd2;
    localparam logic [1:0] SEL_EOI     = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_active;
    logic [NUM_IRQ-1:0] r_prev_irq;
    logic [1:0]         r_arm_cnt;

    logic [NUM_IRQ-1:0] w_irq_s;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_vec_oh;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [NUM_IRQ-1:0] w_pend_keep;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [NUM_IRQ-1:0] w_mask_nxt;
    logic [NUM_IRQ-1:0] w_req_vec;
    logic [VEC_W-1:0]   w_win;
    logic [DATA_W-1:0]  w_rdata;
    logic [1:0]         w_sel;
    logic               w_wr;
    logic               w_rd;
    logic               w_mask_wr;
    logic               w_eoi;
    logic               w_ack_take;
    logic               w_still;
    logic               w_unused_bits;

`ifdef CEESPU_INTC_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    // Two-stage synchronizer for asynchronous interrupt lines
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= I_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = I_irq;
`endif

    // Bus decode; address bits [1:0] and unused data bits are don't-care
    assign w_sel         = I_busAddr[3:2];
    assign w_wr          = I_busE & I_busWe;
    assign w_rd          = I_busE & ~I_busWe;
    assign w_mask_wr     = w_wr && (w_sel == SEL_MASK);
    assign w_eoi         = w_wr && (w_sel == SEL_EOI);
    assign w_w1c         = (w_wr && (w_sel == SEL_PENDING)) ? I_busWData[NUM_IRQ-1:0] : '0;
    assign w_unused_bits = ^{I_busAddr[1:0], I_busWData[DATA_W-1:NUM_IRQ]};

    // Rising edges; new events always win over same-cycle clears
    assign w_edge      = (r_arm_cnt == ARM_CYCLES) ? (w_irq_s & ~r_prev_irq) : '0;
    assign w_ack_take  = (r_state == S_REQ) && I_int_ack;
    assign w_vec_oh    = NUM_IRQ'(1) << O_int_vector;
    assign w_ack_clr   = w_ack_take ? w_vec_oh : '0;
    assign w_pend_keep = (r_pending & ~w_w1c) | w_edge;
    assign w_pend_nxt  = (r_pending & ~(w_w1c | w_ack_clr)) | w_edge;
    assign w_mask_nxt  = w_mask_wr ? I_busWData[NUM_IRQ-1:0] : r_mask;
    assign w_still     = |(w_pend_keep & w_mask_nxt & w_vec_oh);
    assign w_req_vec   = r_pending & r_mask;

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        w_win = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (w_req_vec[i]) w_win = VEC_W'(i);
        end
    end

    // Register read mux; EOI reads as zero
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_PENDING: w_rdata = DATA_W'(r_pending);
            SEL_MASK:    w_rdata = DATA_W'(r_mask);
            SEL_ACTIVE:  w_rdata = DATA_W'(r_active);
            default:     w_rdata = '0;
        endcase
    end

    // Edge tracking, pending/mask registers and registered read data
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_prev_irq <= '0;
            r_arm_cnt  <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            O_busRData <= '0;
        end else begin
            r_prev_irq <= w_irq_s;
            if (r_arm_cnt != ARM_CYCLES) r_arm_cnt <= r_arm_cnt + 2'd1;
            r_pending <= w_pend_nxt;
            r_mask    <= w_mask_nxt;
            if (w_rd) O_busRData <= w_rdata;
        end
    end

    // Request/acknowledge/service sequencing with registered outputs
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            O_int_req    <= 1'b0;
            O_int_vector <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req_vec) begin
                        r_state      <= S_REQ;
                        O_int_req    <= 1'b1;
                        O_int_vector <= w_win;
                    end
                end
                S_REQ: begin
                    if (I_int_ack) begin
                        r_state   <= S_SERVICE;
                        O_int_req <= 1'b0;
                        r_active  <= w_vec_oh;
                    end else if (!w_still) begin
                        r_state   <= S_IDLE;
                        O_int_req <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    O_int_req <= 1'b0;
                    if (w_eoi) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    O_int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_int_ctrl.sv
// Directed-vector bench for ceespu_int_ctrl (default build, unsynchronized irq lines).
module tb_ceespu_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        int_req;
    logic [2:0]  int_vector;
    logic        int_ack;
    logic        bus_e;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    ceespu_int_ctrl #(.NUM_IRQ(8)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_irq        (irq),
        .O_int_req    (int_req),
        .O_int_vector (int_vector),
        .I_int_ack    (int_ack),
        .I_busE       (bus_e),
        .I_busWe      (bus_we),
        .I_busAddr    (bus_addr),
        .I_busWData   (bus_wdata),
        .O_busRData   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_e = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_e = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus_e = 1'b1; bus_we = 1'b0; bus_addr = a;
        tick();
        d = bus_rdata;
        bus_e = 1'b0;
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = m;
        tick();
        irq = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", int_req); end
        n_cmp++; if (int_vector !== 3'd0) begin n_err++; $display("FAIL rst_vec got %0d want 0", int_vector); end
        n_cmp++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", bus_rdata); end
        rst = 1'b0;
        tick();
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_pending got %h want 0", d); end
        bus_read(4'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_mask got %h want 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        bus_write(4'h4, 32'h04);
        pulse_irq(8'h04);
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL single_early got %0b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL single_req got %0b want 1", int_req); end
        n_cmp++; if (int_vector !== 3'd2) begin n_err++; $display("FAIL single_vec got %0d want 2", int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL single_ackreq got %0b want 0", int_req); end
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h04) begin n_err++; $display("FAIL single_active got %h want 04", d); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL single_pending got %h want 0", d); end
        bus_write(4'hC, 32'h0);
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL single_eoi_active got %h want 0", d); end
        bus_read(4'hC, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL eoi_reads0 got %h want 0", d); end
    endtask

    task automatic test_priority();
        bus_write(4'h4, 32'hFF);
        pulse_irq(8'h22);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd1) begin n_err++; $display("FAIL prio_first got req=%0b vec=%0d want 1/1", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL prio_eoi_gap got %0b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd5) begin n_err++; $display("FAIL prio_second got req=%0b vec=%0d want 1/5", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
    endtask

    task automatic test_no_nesting();
        logic [31:0] d;
        pulse_irq(8'h02);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd1) begin n_err++; $display("FAIL nest_req got req=%0b vec=%0d want 1/1", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        pulse_irq(8'h01);
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL nest_blocked got %0b want 0", int_req); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h01) begin n_err++; $display("FAIL nest_pending got %h want 01", d); end
        bus_write(4'hC, 32'h0);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd0) begin n_err++; $display("FAIL nest_after_eoi got req=%0b vec=%0d want 1/0", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
    endtask

    task automatic test_no_rearb();
        pulse_irq(8'h08);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd3) begin n_err++; $display("FAIL rearb_first got req=%0b vec=%0d want 1/3", int_req, int_vector); end
        pulse_irq(8'h01);
        tick(); tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd3) begin n_err++; $display("FAIL rearb_hold got req=%0b vec=%0d want 1/3", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd0) begin n_err++; $display("FAIL rearb_next got req=%0b vec=%0d want 1/0", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        bus_write(4'h4, 32'h00);
        pulse_irq(8'h08);
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL wd_masked got %0b want 0", int_req); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h08) begin n_err++; $display("FAIL wd_pending got %h want 08", d); end
        bus_write(4'h4, 32'h08);
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL wd_mask_gap got %0b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd3) begin n_err++; $display("FAIL wd_req got req=%0b vec=%0d want 1/3", int_req, int_vector); end
        bus_write(4'h0, 32'h08);
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL wd_w1c got %0b want 0", int_req); end
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL wd_idle got %0b want 0", int_req); end
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wd_active got %h want 0", d); end
        // ack in the same cycle as the W1C that would withdraw: ack wins
        pulse_irq(8'h08);
        tick();
        bus_e = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h08; int_ack = 1'b1;
        tick();
        bus_e = 1'b0; bus_we = 1'b0; bus_wdata = '0; int_ack = 1'b0;
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h08) begin n_err++; $display("FAIL wd_ackwins_active got %h want 08", d); end
        bus_write(4'hC, 32'h0);
        // mask drop also withdraws but leaves the event pending
        pulse_irq(8'h08);
        tick();
        bus_write(4'h4, 32'h00);
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL wd_maskdrop got %0b want 0", int_req); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h08) begin n_err++; $display("FAIL wd_maskdrop_pend got %h want 08", d); end
        bus_write(4'h0, 32'h08);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        pulse_irq(8'h10);
        tick();
        bus_e = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h10; irq = 8'h10;
        tick();
        bus_e = 1'b0; bus_we = 1'b0; bus_wdata = '0; irq = '0;
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL setwin_w1c got %h want 10", d); end
        bus_write(4'h0, 32'h10);
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_plain got %h want 0", d); end
        // new edge in the ack cycle survives the ack-clear
        bus_write(4'h4, 32'h10);
        pulse_irq(8'h10);
        tick();
        irq = 8'h10; int_ack = 1'b1;
        tick();
        irq = '0; int_ack = 1'b0;
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL setwin_ackreq got %0b want 0", int_req); end
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL setwin_active got %h want 10", d); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL setwin_ack got %h want 10", d); end
        bus_write(4'hC, 32'h0);
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd4) begin n_err++; $display("FAIL setwin_rereq got req=%0b vec=%0d want 1/4", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_write(4'hC, 32'h0);
    endtask

    task automatic test_boundaries();
        logic [31:0] d;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL stray_ack got %h want 0", d); end
        pulse_irq(8'h10);
        tick();
        pulse_irq(8'h10);
        bus_write(4'hC, 32'h0);
        n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL stray_eoi got %0b want 1", int_req); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL stray_eoi_active got %h want 10", d); end
        bus_write(4'hC, 32'h0);
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL collapse_req got %0b want 0", int_req); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL collapse_pend got %h want 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(4'h4, 32'h04);
        irq = 8'h04;
        tick(); tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd2) begin n_err++; $display("FAIL rmid_req got req=%0b vec=%0d want 1/2", int_req, int_vector); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (int_req !== 1'b0 || int_vector !== 3'd0) begin n_err++; $display("FAIL rmid_out got req=%0b vec=%0d want 0/0", int_req, int_vector); end
        n_cmp++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_rdata got %h want 0", bus_rdata); end
        tick();
        bus_read(4'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rmid_mask got %h want 0", d); end
        bus_read(4'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rmid_active got %h want 0", d); end
        bus_write(4'h4, 32'h04);
        tick(); tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL rmid_held got %0b want 0", int_req); end
        bus_read(4'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rmid_pend got %h want 0", d); end
        irq = 8'h00; tick();
        irq = 8'h04; tick();
        n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL rmid_rise_early got %0b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vector !== 3'd2) begin n_err++; $display("FAIL rmid_rise got req=%0b vec=%0d want 1/2", int_req, int_vector); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 8'h00;
        bus_write(4'hC, 32'h0);
    endtask

    initial begin
        rst = 1'b1; irq = '0; int_ack = 1'b0;
        bus_e = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        test_reset();
        test_single();
        test_priority();
        test_no_nesting();
        test_no_rearb();
        test_withdraw();
        test_set_wins();
        test_boundaries();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
